// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM encoding, mode constants,
// datapath status flags and the controller-to-datapath command.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_EUCLID = 1'b0;
    localparam logic MODE_STEIN  = 1'b1;

    // Status returned by the datapath every cycle
    typedef struct packed {
        logic a_zero;
        logic b_zero;
        logic a_eq_b;
        logic a_gt_b;
        logic a_even;
        logic b_even;
    } flags_t;

    // One datapath operation per cycle, chosen by the controller
    typedef enum logic [3:0] {
        OP_HOLD      = 4'd0,
        OP_LOAD      = 4'd1,  // capture operands, clear k
        OP_SUB_A     = 4'd2,  // A <= A - B
        OP_SUB_B     = 4'd3,  // B <= B - A
        OP_HALF_BOTH = 4'd4,  // A >>= 1, B >>= 1, k++
        OP_HALF_A    = 4'd5,  // A >>= 1
        OP_HALF_B    = 4'd6,  // B >>= 1
        OP_SUBH_A    = 4'd7,  // A <= (A - B) >> 1
        OP_SUBH_B    = 4'd8   // B <= (B - A) >> 1
    } dp_op_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: A/B/k registers, comparators and the subtract/shift
// network. It executes whatever operation the controller selects and
// reports operand status flags back.
module gcd_dp
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  dp_op_t           op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output flags_t           flags,
    output logic [WIDTH-1:0] a_val,
    output logic [WIDTH-1:0] or_val,
    output logic [WIDTH-1:0] shl_val
);

    localparam int K_W = $clog2(WIDTH) + 1;
    localparam logic [K_W-1:0] K_ONE = {{(K_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [K_W-1:0]   k_q;

    // Operand and common-power-of-two registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            k_q <= '0;
        end else begin
            case (op)
                OP_LOAD: begin
                    a_q <= a_in;
                    b_q <= b_in;
                    k_q <= '0;
                end
                OP_SUB_A:  a_q <= a_q - b_q;
                OP_SUB_B:  b_q <= b_q - a_q;
                OP_HALF_BOTH: begin
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    k_q <= k_q + K_ONE;
                end
                OP_HALF_A: a_q <= a_q >> 1;
                OP_HALF_B: b_q <= b_q >> 1;
                OP_SUBH_A: a_q <= (a_q - b_q) >> 1;
                OP_SUBH_B: b_q <= (b_q - a_q) >> 1;
                default: ;
            endcase
        end
    end

    // Status flags and result candidates
    always_comb begin
        flags.a_zero = (a_q == '0);
        flags.b_zero = (b_q == '0);
        flags.a_eq_b = (a_q == b_q);
        flags.a_gt_b = (a_q > b_q);
        flags.a_even = ~a_q[0];
        flags.b_even = ~b_q[0];
        a_val        = a_q;
        or_val       = a_q | b_q;
        shl_val      = a_q << k_q;
    end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: controller FSM (busy/done, cycle counter, result
// capture) driving the gcd_dp datapath. Euclid subtraction or Stein
// binary algorithm, selected per request.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic             mode_q;
    dp_op_t           op;
    flags_t           flags;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] or_val;
    logic [WIDTH-1:0] shl_val;
    logic             any_zero;

    assign any_zero = flags.a_zero | flags.b_zero;

    gcd_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .a_in    (a_in),
        .b_in    (b_in),
        .flags   (flags),
        .a_val   (a_val),
        .or_val  (or_val),
        .shl_val (shl_val)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: zero path wins, then per-mode termination test
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = CALC;
            CALC: begin
                if (any_zero)
                    state_nx = DONE;
                else if (mode_q == MODE_EUCLID)
                    state_nx = flags.a_eq_b ? DONE : CALC;
                else if (!flags.a_even && !flags.b_even && flags.a_eq_b)
                    state_nx = SHIFT;
            end
            SHIFT: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs and datapath command; Stein rules apply in priority order
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        op   = OP_HOLD;
        case (state)
            IDLE: if (start) op = OP_LOAD;
            CALC: begin
                busy = 1'b1;
                if (!any_zero) begin
                    if (mode_q == MODE_EUCLID) begin
                        if (!flags.a_eq_b)
                            op = flags.a_gt_b ? OP_SUB_A : OP_SUB_B;
                    end else if (flags.a_even && flags.b_even) begin
                        op = OP_HALF_BOTH;
                    end else if (flags.a_even) begin
                        op = OP_HALF_A;
                    end else if (flags.b_even) begin
                        op = OP_HALF_B;
                    end else if (!flags.a_eq_b) begin
                        op = flags.a_gt_b ? OP_SUBH_A : OP_SUBH_B;
                    end
                end
            end
            SHIFT: busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Mode capture, saturating cycle counter and result/err capture;
    // these hold from DONE until the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_EUCLID;
            cycles <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_q <= mode;
                    cycles <= '0;
                    err    <= 1'b0;
                end
                CALC: begin
                    if (cycles != '1) cycles <= cycles + CNT_ONE;
                    if (any_zero) begin
                        result <= or_val;
                        err    <= flags.a_zero & flags.b_zero;
                    end else if (mode_q == MODE_EUCLID && flags.a_eq_b) begin
                        result <= a_val;
                    end
                end
                SHIFT: begin
                    if (cycles != '1) cycles <= cycles + CNT_ONE;
                    result <= shl_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and random checks for gcd_engine (WIDTH=16).
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        err;
    logic [15:0] cycles;

    int n_chk  = 0;
    int n_pass = 0;

    gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .cycles (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Caller is at a negedge with the engine idle. Optionally injects a
    // competing start (10/4, Stein) at loop step inj_at. exp_cyc < 0 skips
    // the absolute cycle-count check.
    task automatic run_op(input string tag, input logic m, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp_res,
                          input logic exp_err, input int exp_cyc, input int inj_at);
        int busy_n = 0;
        int t = 0;
        start = 1'b1; mode = m; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; mode = ~m; a_in = 16'hdead; b_in = 16'hbeef;
        check({tag, "_busy"}, busy, 1);
        while (!done && t < 3000) begin
            if (busy) busy_n++;
            if (t == inj_at) begin
                start = 1'b1; mode = 1'b1; a_in = 16'd10; b_in = 16'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_cycles_vs_busy"}, cycles, busy_n);
        if (exp_cyc >= 0) check({tag, "_cycles"}, cycles, exp_cyc);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_result_hold"}, result, exp_res);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int dcnt;
        rst = 1'b1; start = 1'b1; mode = 1'b0; a_in = 16'd9; b_in = 16'd6;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_cycles", cycles, 0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_op("euclid", 1'b0, 16'd143, 16'd78, 16'd13, 1'b0, 7, -1);
        run_op("stein", 1'b1, 16'd48, 16'd18, 16'd6, 1'b0, 7, -1);
        run_op("zero_e", 1'b0, 16'd0, 16'd25, 16'd25, 1'b0, 1, -1);
        run_op("zero_s", 1'b1, 16'd0, 16'd25, 16'd25, 1'b0, 1, -1);
        run_op("both_zero", 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1, -1);
        run_op("err_clear", 1'b1, 16'd7, 16'd7, 16'd7, 1'b0, 2, -1);
        run_op("ignore_start", 1'b0, 16'd143, 16'd78, 16'd13, 1'b0, 7, 2);
        run_op("stein_pow2", 1'b1, 16'h8000, 16'h4000, 16'h4000, 1'b0, 17, -1);
        run_op("stein_max", 1'b1, 16'hffff, 16'hffff, 16'hffff, 1'b0, 2, -1);

        // Reset in the middle of a computation
        start = 1'b1; mode = 1'b0; a_in = 16'd143; b_in = 16'd78;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_cycles", cycles, 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("midrst_no_activity", dcnt, 0);
        run_op("post_rst", 1'b0, 16'd21, 16'd14, 16'd7, 1'b0, 3, -1);

        // Random pairs; Euclid operands kept small to bound run time
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(0, 1023));
            rb = 16'($urandom_range(1, 1023));
            run_op("rand_euclid", 1'b0, ra, rb, ref_gcd(ra, rb), 1'b0, -1, -1);
        end
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom_range(1, 65535));
            rb = 16'($urandom_range(0, 65535));
            run_op("rand_stein", 1'b1, ra, rb, ref_gcd(ra, rb), 1'b0, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
